// File: rtl/dilithium_pkg.sv
// dilithium_pkg: shared Dilithium constants and the power2round job FSM encoding.
package dilithium_pkg;

    localparam int N = 256;
    localparam int Q = 8380417;
    localparam int D = 13;
    localparam int P2R_BIAS = (1 << (D - 1)) - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

endpackage

// File: rtl/power2round.sv
// power2round: combinational split of one coefficient into high (a1) and low (a0) parts.
module power2round
    import dilithium_pkg::*;
(
    input  logic signed [31:0] a_i,
    output logic signed [31:0] a1_o,
    output logic signed [31:0] a0_o
);

    assign a1_o = (a_i + P2R_BIAS) >>> D;
    assign a0_o = a_i - (a1_o <<< D);

endmodule

// File: rtl/polyvec_power2round_seq.sv
// polyvec_power2round_seq: streams K*256 coefficients from a source RAM through power2round
// in a read / capture+compute / output pipeline with wr_ready backpressure.
module polyvec_power2round_seq
    import dilithium_pkg::*;
#(
    parameter int K      = 4,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic signed [31:0]  rd_data,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic signed [31:0]  t0_data,
    output logic signed [31:0]  t1_data,
    input  logic                wr_ready
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(K * N - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  rd_cnt_q, wr_cnt_q;
    logic               cap_v_q, cap_hold_q, out_v_q;
    logic signed [31:0] cap_data_q, cap_val, a1, a0, t0_q, t1_q;
    logic               launch, out_free, wr_fire;

    assign launch   = (state_q == IDLE) && start;
    assign out_free = !out_v_q || wr_ready;
    assign wr_fire  = out_v_q && wr_ready;
    // RAM data is only valid the cycle after a read, so a stalled capture keeps its own copy.
    assign cap_val  = cap_hold_q ? cap_data_q : rd_data;

    assign rd_addr = rd_cnt_q;
    assign wr_en   = out_v_q;
    assign wr_addr = wr_cnt_q;
    assign t0_data = t0_q;
    assign t1_data = t1_q;

    power2round u_p2r (
        .a_i  (cap_val),
        .a1_o (a1),
        .a0_o (a0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (rd_en && rd_cnt_q == LAST) ? DRAIN : RUN;
            DRAIN:   state_d = (wr_fire && wr_cnt_q == LAST) ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A read may only issue if the capture slot will be empty when its data lands.
    always_comb begin
        busy  = (state_q == RUN) || (state_q == DRAIN);
        done  = (state_q == DONE);
        rd_en = (state_q == RUN) && (!cap_v_q || out_free);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            cap_v_q    <= 1'b0;
            cap_hold_q <= 1'b0;
            cap_data_q <= '0;
            out_v_q    <= 1'b0;
            t0_q       <= '0;
            t1_q       <= '0;
        end else begin
            if (launch) begin
                rd_cnt_q <= '0;
                wr_cnt_q <= '0;
            end else begin
                if (rd_en)   rd_cnt_q <= rd_cnt_q + 1'b1;
                if (wr_fire) wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            cap_v_q    <= rd_en || (cap_v_q && !out_free);
            cap_hold_q <= cap_v_q && !out_free;
            cap_data_q <= cap_val;
            if (out_free) begin
                out_v_q <= cap_v_q;
                if (cap_v_q) begin
                    t0_q <= a0;
                    t1_q <= a1;
                end
            end
        end
    end

endmodule

// File: tb/tb_polyvec_power2round_seq.sv
// tb_polyvec_power2round_seq: scoreboard bench with a 1-cycle-latency RAM model and
// optional random wr_ready backpressure.
module tb_polyvec_power2round_seq;

    localparam int K  = 4;
    localparam int AW = 10;
    localparam int NC = K * 256;
    localparam int Q  = 8380417;

    logic               clk = 1'b0, rst_n = 1'b0, start = 1'b0, wr_ready = 1'b1;
    logic               busy, done, rd_en, wr_en;
    logic [AW-1:0]      rd_addr, wr_addr;
    logic signed [31:0] rd_data = '0, t0_data, t1_data;

    typedef struct {int addr; int t1; int t0;} exp_t;
    exp_t sb[$];

    int mem[NC];
    int got_t1[NC];
    int got_t0[NC];
    int checks = 0, errs = 0, wr_cnt = 0, done_cnt = 0, nxt_rd = 0;
    bit rand_ready = 1'b0;
    bit stall_q = 1'b0;
    logic [AW-1:0]      st_addr;
    logic signed [31:0] st_t0, st_t1;

    always #5 clk = ~clk;

    polyvec_power2round_seq #(.K(K), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .t0_data(t0_data), .t1_data(t1_data),
        .wr_ready(wr_ready)
    );

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    initial forever begin
        @(posedge clk);
        #1 wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            stall_q = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (stall_q) begin
                checks++;
                if (!wr_en || wr_addr !== st_addr || t0_data !== st_t0 || t1_data !== st_t1) begin
                    errs++;
                    $display("FAIL stall_hold: got wr_en=%0b addr=%0d t1=%0d t0=%0d, required addr=%0d t1=%0d t0=%0d",
                             wr_en, wr_addr, t1_data, t0_data, st_addr, st_t1, st_t0);
                end
            end
            stall_q = wr_en && !wr_ready;
            st_addr = wr_addr; st_t0 = t0_data; st_t1 = t1_data;
            if (wr_en && wr_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_write: addr=%0d with empty scoreboard", wr_addr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (int'(wr_addr) !== e.addr || t1_data !== e.t1 || t0_data !== e.t0) begin
                        errs++;
                        $display("FAIL write_data: got addr=%0d t1=%0d t0=%0d, required addr=%0d t1=%0d t0=%0d",
                                 wr_addr, t1_data, t0_data, e.addr, e.t1, e.t0);
                    end
                end
                got_t1[wr_addr] = t1_data;
                got_t0[wr_addr] = t0_data;
                wr_cnt++;
            end
            if (rd_en) begin
                exp_t e;
                checks++;
                if (int'(rd_addr) !== nxt_rd || sb.size() > 1) begin
                    errs++;
                    $display("FAIL read_issue: got addr=%0d in_flight=%0d, required addr=%0d in_flight<=1",
                             rd_addr, sb.size(), nxt_rd);
                end
                e.addr = nxt_rd;
                e.t1   = (mem[nxt_rd] + 4095) / 8192;
                e.t0   = mem[nxt_rd] - e.t1 * 8192;
                sb.push_back(e);
                nxt_rd++;
            end
        end
    end

    task automatic run_job(input bit rnd, output int cyc);
        rand_ready = rnd;
        nxt_rd = 0; wr_cnt = 0; done_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        while (!done && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            errs++;
            $display("FAIL job_timeout: no done after %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL reset_status: busy=%0b done=%0b, required 0 0", busy, done);
        end
        if (rd_en !== 1'b0 || wr_en !== 1'b0) begin
            errs++; $display("FAIL reset_enables: rd_en=%0b wr_en=%0b, required 0 0", rd_en, wr_en);
        end
        if (rd_addr !== '0 || wr_addr !== '0) begin
            errs++; $display("FAIL reset_addr: rd=%0d wr=%0d, required 0 0", rd_addr, wr_addr);
        end
        if (t0_data !== 32'sd0 || t1_data !== 32'sd0) begin
            errs++; $display("FAIL reset_data: t0=%0d t1=%0d, required 0 0", t0_data, t1_data);
        end
        rst_n = 1'b1;
        nxt_rd = 0; wr_cnt = 0; done_cnt = 0; rand_ready = 1'b0;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errs++; $display("FAIL start_after_reset: busy=%0b, required 1", busy);
        end
        cyc = 1;
        while (!done && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== NC + 3) begin
            errs++; $display("FAIL first_job_len: got %0d cycles, required %0d", cyc, NC + 3);
        end
    endtask

    task automatic test_vectors();
        int cyc;
        int vin[4] = '{0, 4096, 4097, 8380416};
        int vt1[4] = '{0, 0, 1, 1023};
        int vt0[4] = '{0, 4096, -4095, 0};
        for (int i = 0; i < 4; i++) mem[i] = vin[i];
        run_job(1'b0, cyc);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_t1[i] !== vt1[i] || got_t0[i] !== vt0[i]) begin
                errs++;
                $display("FAIL vector_%0d: got (t1,t0)=(%0d,%0d), required (%0d,%0d)", i, got_t1[i], got_t0[i], vt1[i], vt0[i]);
            end
        end
    endtask

    task automatic test_full_job();
        int cyc;
        run_job(1'b0, cyc);
        checks += 4;
        if (cyc !== NC + 3) begin
            errs++; $display("FAIL job_latency: got %0d cycles, required %0d", cyc, NC + 3);
        end
        if (busy !== 1'b0) begin
            errs++; $display("FAIL busy_in_done: got %0b, required 0", busy);
        end
        if (wr_cnt !== NC) begin
            errs++; $display("FAIL write_count: got %0d, required %0d", wr_cnt, NC);
        end
        if (sb.size() !== 0) begin
            errs++; $display("FAIL leftover: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_random_stall();
        int cyc;
        run_job(1'b1, cyc);
        checks += 2;
        if (wr_cnt !== NC) begin
            errs++; $display("FAIL stall_write_count: got %0d, required %0d", wr_cnt, NC);
        end
        if (sb.size() !== 0) begin
            errs++; $display("FAIL stall_leftover: got %0d pending, required 0", sb.size());
        end
        rand_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        int cyc;
        rand_ready = 1'b0;
        nxt_rd = 0; wr_cnt = 0; done_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!done && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);
        checks += 3;
        if (busy !== 1'b0) begin
            errs++; $display("FAIL start_in_done: busy=%0b, required 0", busy);
        end
        if (done_cnt !== 1) begin
            errs++; $display("FAIL done_pulses: got %0d, required 1", done_cnt);
        end
        if (wr_cnt !== NC) begin
            errs++; $display("FAIL ignored_start_writes: got %0d, required %0d", wr_cnt, NC);
        end
        run_job(1'b0, cyc);
        checks++;
        if (cyc !== NC + 3 || wr_cnt !== NC) begin
            errs++; $display("FAIL restart_job: got %0d cycles %0d writes, required %0d %0d", cyc, wr_cnt, NC + 3, NC);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, pulses;
        rand_ready = 1'b0;
        nxt_rd = 0; wr_cnt = 0; done_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (wr_cnt < 500 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_en, wr_en} !== 4'b0 || rd_addr !== '0 || wr_addr !== '0 || t0_data !== 32'sd0 || t1_data !== 32'sd0) begin
            errs++;
            $display("FAIL abort_outputs: busy=%0b done=%0b rd_en=%0b wr_en=%0b rd=%0d wr=%0d t0=%0d t1=%0d, required all 0",
                     busy, done, rd_en, wr_en, rd_addr, wr_addr, t0_data, t1_data);
        end
        sb.delete();
        stall_q = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0 || busy !== 1'b0) begin
            errs++; $display("FAIL abort_no_done: pulses=%0d busy=%0b, required 0 0", pulses, busy);
        end
        run_job(1'b0, cyc);
        checks++;
        if (cyc !== NC + 3 || wr_cnt !== NC) begin
            errs++; $display("FAIL job_after_abort: got %0d cycles %0d writes, required %0d %0d", cyc, wr_cnt, NC + 3, NC);
        end
    endtask

    initial begin
        for (int i = 0; i < NC; i++) mem[i] = int'($urandom_range(0, Q - 1));
        mem[NC - 1] = Q - 1;
        test_reset();
        test_vectors();
        test_full_job();
        test_random_stall();
        test_ignored_start();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
